bbox_msg_reader: RTL

//  Avalon-MM master that drains the bounding-box message FIFO of the image processor over its MM slave port.

---
 rtl/bbox_msg_pkg.sv | 37 +++
 rtl/mm_read_pulse.sv | 32 +++
 rtl/bbox_msg_reader.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/bbox_msg_pkg.sv
// Shared definitions for the bounding-box message reader: register map, message
// framing constants, FSM state encoding and the coordinate type.
package bbox_msg_pkg;

   localparam logic [2:0]  ADDR_STATUS = 3'd0;
   localparam logic [2:0]  ADDR_MSG    = 3'd1;
   localparam logic [2:0]  ADDR_ID     = 3'd2;
   localparam logic [2:0]  ADDR_BBCOL  = 3'd3;

   localparam logic [31:0] MSG_ID_DEFAULT = 32'h00524242;
   localparam logic [31:0] FLUSH_CMD      = 32'h0000_0010;
   localparam logic [7:0]  MSG_WORDS      = 8'd3;

   // usedw field of the status word and the two coordinate fields of a message word
   localparam int STAT_WORDS_LSB = 8;
   localparam int STAT_WORDS_MSB = 15;
   localparam int COORD_HI_LSB   = 16;
   localparam int COORD_HI_MSB   = 26;
   localparam int COORD_LO_MSB   = 10;

   typedef logic [10:0] coord_t;

   typedef enum logic [3:0] {
      IDLE,
      RD_STAT,
      WT_STAT,
      RD_ID,
      WT_ID,
      RD_TL,
      WT_TL,
      RD_BR,
      WT_BR,
      UPD,
      ERR
   } state_t;

endpackage

// File: rtl/mm_read_pulse.sv
// Single-beat Avalon-MM read helper: one strobe cycle, data returned with done
// on the following cycle. A strobe can never follow another strobe directly.
module mm_read_pulse
   import bbox_msg_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start_i,
   input  logic [2:0]  addr_i,
   output logic        m_read_o,
   output logic [2:0]  m_address_o,
   input  logic [31:0] m_readdata_i,
   output logic [31:0] data_o,
   output logic        done_o
);

   logic pend_q;

   assign m_read_o    = start_i & ~pend_q;
   assign m_address_o = m_read_o ? addr_i : ADDR_STATUS;
   assign done_o      = pend_q;
   assign data_o      = m_readdata_i;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_q <= 1'b0;
      end else begin
         pend_q <= m_read_o;
      end
   end

endmodule

// File: rtl/bbox_msg_reader.sv
// Avalon-MM master that polls the image processor's bounding-box FIFO and presents
// each RBB message as registered box edges. Build option: BBOX_MSG_READER_FLUSH_EN.
module bbox_msg_reader
   import bbox_msg_pkg::*;
#(
   parameter int          POLL_INTERVAL = 1024,
   parameter logic [31:0] MSG_ID        = MSG_ID_DEFAULT,
   parameter int          CNT_W         = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   output logic             m_chipselect,
   output logic             m_read,
   output logic             m_write,
   output logic [2:0]       m_address,
   output logic [31:0]      m_writedata,
   input  logic [31:0]      m_readdata,
   input  logic             enable,
   output logic             box_valid,
   output logic             box_empty,
   output logic [10:0]      box_left,
   output logic [10:0]      box_top,
   output logic [10:0]      box_right,
   output logic [10:0]      box_bottom,
   output logic [10:0]      box_mid_x,
   output logic [10:0]      box_mid_y,
   output logic [CNT_W-1:0] msg_count,
   output logic [7:0]       err_count
);

   localparam int               TMR_W      = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
   localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(POLL_INTERVAL - 1);

   // Sum is 12 bits wide so right edges near 2047 do not wrap before halving.
   function automatic coord_t coord_mid(input coord_t a, input coord_t b);
      logic [11:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[11:1];
   endfunction

   state_t           state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [7:0]       words_q, words_d;
   logic             rd_start, rd_done;
   logic [2:0]       rd_addr;
   logic [31:0]      rd_data;
   logic             upd, err_inc;

   coord_t cap_l_q, cap_t_q, cap_r_q, cap_b_q;
   coord_t left_q, top_q, right_q, bottom_q, mid_x_q, mid_y_q;
   logic             empty_q, valid_q;
   logic [CNT_W-1:0] msg_cnt_q;
   logic [7:0]       err_cnt_q;

   mm_read_pulse u_rd (
      .clk          (clk),
      .reset_n      (reset_n),
      .start_i      (rd_start),
      .addr_i       (rd_addr),
      .m_read_o     (m_read),
      .m_address_o  (m_address),
      .m_readdata_i (m_readdata),
      .data_o       (rd_data),
      .done_o       (rd_done)
   );

   always_comb begin
      state_d  = state_q;
      tmr_d    = tmr_q;
      words_d  = words_q;
      rd_start = 1'b0;
      rd_addr  = ADDR_STATUS;
      upd      = 1'b0;
      err_inc  = 1'b0;
      case (state_q)
         IDLE: begin
            if (tmr_q != '0)   tmr_d   = tmr_q - 1'b1;
            else if (enable)   state_d = RD_STAT;
         end
         RD_STAT: begin
            rd_start = 1'b1;
            rd_addr  = ADDR_STATUS;
            state_d  = WT_STAT;
         end
         WT_STAT: if (rd_done) begin
            words_d = rd_data[STAT_WORDS_MSB:STAT_WORDS_LSB];
            if (rd_data[STAT_WORDS_MSB:STAT_WORDS_LSB] >= MSG_WORDS) begin
               state_d = RD_ID;
            end else begin
               tmr_d   = TMR_RELOAD;
               state_d = IDLE;
            end
         end
         RD_ID: begin
            rd_start = 1'b1;
            rd_addr  = ADDR_MSG;
            state_d  = WT_ID;
         end
         WT_ID: if (rd_done) begin
            if (rd_data == MSG_ID) begin
               state_d = RD_TL;
            end else begin
               err_inc = 1'b1;
               state_d = ERR;
            end
         end
         RD_TL: begin
            rd_start = 1'b1;
            rd_addr  = ADDR_MSG;
            state_d  = WT_TL;
         end
         WT_TL: if (rd_done) state_d = RD_BR;
         RD_BR: begin
            rd_start = 1'b1;
            rd_addr  = ADDR_MSG;
            state_d  = WT_BR;
         end
         WT_BR: if (rd_done) state_d = UPD;
         UPD: begin
            upd = 1'b1;
            if (((words_q - MSG_WORDS) >= MSG_WORDS) && enable) begin
               state_d = RD_STAT;
            end else begin
               tmr_d   = TMR_RELOAD;
               state_d = IDLE;
            end
         end
         ERR: begin
`ifdef BBOX_MSG_READER_FLUSH_EN
            tmr_d   = TMR_RELOAD;
            state_d = IDLE;
`else
            // Bad word already popped; the next word is tried as an ID.
            state_d = RD_STAT;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         tmr_q     <= TMR_RELOAD;
         words_q   <= '0;
         left_q    <= '0;
         top_q     <= '0;
         right_q   <= '0;
         bottom_q  <= '0;
         mid_x_q   <= '0;
         mid_y_q   <= '0;
         empty_q   <= 1'b0;
         valid_q   <= 1'b0;
         msg_cnt_q <= '0;
         err_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         words_q <= words_d;
         valid_q <= upd;
         if (upd) begin
            left_q    <= cap_l_q;
            top_q     <= cap_t_q;
            right_q   <= cap_r_q;
            bottom_q  <= cap_b_q;
            mid_x_q   <= coord_mid(cap_l_q, cap_r_q);
            mid_y_q   <= coord_mid(cap_t_q, cap_b_q);
            empty_q   <= (cap_l_q > cap_r_q) || (cap_t_q > cap_b_q);
            msg_cnt_q <= msg_cnt_q + 1'b1;
         end
         if (err_inc && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 1'b1;
      end
   end

   // Staging for a message in flight; only UPD copies it to the outputs.
   always_ff @(posedge clk) begin
      if (state_q == WT_TL && rd_done) begin
         cap_l_q <= rd_data[COORD_HI_MSB:COORD_HI_LSB];
         cap_t_q <= rd_data[COORD_LO_MSB:0];
      end
      if (state_q == WT_BR && rd_done) begin
         cap_r_q <= rd_data[COORD_HI_MSB:COORD_HI_LSB];
         cap_b_q <= rd_data[COORD_LO_MSB:0];
      end
   end

`ifdef BBOX_MSG_READER_FLUSH_EN
   assign m_write     = (state_q == ERR);
   assign m_writedata = m_write ? FLUSH_CMD : '0;
`else
   assign m_write     = 1'b0;
   assign m_writedata = '0;
`endif

   assign m_chipselect = m_read | m_write;
   assign box_valid    = valid_q;
   assign box_empty    = empty_q;
   assign box_left     = left_q;
   assign box_top      = top_q;
   assign box_right    = right_q;
   assign box_bottom   = bottom_q;
   assign box_mid_x    = mid_x_q;
   assign box_mid_y    = mid_y_q;
   assign msg_count    = msg_cnt_q;
   assign err_count    = err_cnt_q;

endmodule
